// File: rtl/wb_pkg.sv
// Shared types for the writeback unit: RV32I load types and the load-queue entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wb_pkg;

  // Entry field widths; writeback_unit checks its parameters against these.
  localparam int WB_IDX_W  = 5;
  localparam int WB_DATA_W = 32;

  // RV32I load funct3 encodings; 011, 110 and 111 fall back to LW.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_type_e;

  // One pending register write: destination and already-extended value.
  typedef struct packed {
    logic [WB_IDX_W-1:0]  rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result queue: FIFO of writeback entries, wraps modulo DEPTH.
// Latency: an entry pushed at edge N is visible on head from cycle N+1.
// Backpressure: full/empty are exported; caller never pushes when full or pops when empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_dat,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_fifo: DEPTH must be a power of two and at least 2");
  end

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: merges ALU results and extended load results onto one register-file write port and keeps the busy scoreboard.
// Latency: ALU result on rf_wen one cycle after acceptance; load result at least two cycles (via the load queue).
// Backpressure: ld_ready and alu_ready both drop while the load queue is full; an accepted ALU result always wins the write slot.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REG    = 32,
  parameter int IDX_WIDTH  = $clog2(NUM_REG),
  parameter int LQ_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [IDX_WIDTH-1:0]  issue_rd,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [IDX_WIDTH-1:0]  alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [IDX_WIDTH-1:0]  ld_rd,
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_addr_lo,
  input  logic [31:0]           ld_word,
  output logic                  rf_wen,
  output logic [IDX_WIDTH-1:0]  rf_rd,
  output logic [DATA_WIDTH-1:0] rf_rdv,
  output logic [NUM_REG-1:0]    busy
);

  if (IDX_WIDTH != WB_IDX_W || DATA_WIDTH != WB_DATA_W) begin : g_bad_width
    $error("writeback_unit: IDX_WIDTH/DATA_WIDTH must match the wb_entry_t field widths");
  end

  logic              lq_full;
  logic              lq_empty;
  logic              lq_pop;
  logic              alu_fire;
  logic              ld_fire;
  logic              sel_vld;
  wb_entry_t         lq_in;
  wb_entry_t         lq_head;
  wb_entry_t         sel;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;
  logic [NUM_REG-1:0] busy_set;
  logic [NUM_REG-1:0] busy_clr;

  // Both channels stall together on a full queue so a stalled ALU result lets the queue drain
  assign ld_ready  = ~lq_full;
  assign alu_ready = ~lq_full;
  assign alu_fire  = alu_valid & alu_ready;
  assign ld_fire   = ld_valid & ld_ready;

  // Pick the addressed halfword/byte and extend according to the load type
  always_comb begin
    ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_byte = ld_addr_lo[0] ? ld_half[15:8] : ld_half[7:0];
    case (ld_type_e'(ld_funct3))
      LB:      ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LBU:     ld_ext = {24'd0, ld_byte};
      LH:      ld_ext = {{16{ld_half[15]}}, ld_half};
      LHU:     ld_ext = {16'd0, ld_half};
      default: ld_ext = ld_word;
    endcase
    lq_in.rd   = ld_rd;
    lq_in.data = ld_ext;
  end

  wb_fifo #(
    .DEPTH (LQ_DEPTH),
    .T     (wb_entry_t)
  ) u_lq (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ld_fire),
    .push_dat (lq_in),
    .pop      (lq_pop),
    .head     (lq_head),
    .empty    (lq_empty),
    .full     (lq_full)
  );

  // Arbitrate the single write slot: accepted ALU result first, else the oldest queued load
  always_comb begin
    sel.rd   = alu_rd;
    sel.data = alu_data;
    sel_vld  = alu_fire;
    lq_pop   = 1'b0;
    if (!alu_fire && !lq_empty) begin
      sel     = lq_head;
      sel_vld = 1'b1;
      lq_pop  = 1'b1;
    end
  end

  // Register the selected write; x0 writes use the slot but never raise rf_wen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen <= 1'b0;
      rf_rd  <= '0;
      rf_rdv <= '0;
    end else begin
      rf_wen <= sel_vld && (sel.rd != '0);
      rf_rd  <= sel_vld ? sel.rd : '0;
      rf_rdv <= sel_vld ? sel.data : '0;
    end
  end

  // Scoreboard set/clear masks; x0 is never tracked
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue_valid) busy_set[issue_rd] = 1'b1;
    if (rf_wen)      busy_clr[rf_rd]    = 1'b1;
    busy_set[0] = 1'b0;
  end

  // Clear on commit, set on issue; a same-edge set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
    end
  end

  // Re-issue is legal only in the cycle the previous write to that register commits
  a_issue_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (issue_valid && issue_rd != '0) |-> (!busy[issue_rd] || (rf_wen && rf_rd == issue_rd)))
    else $error("writeback_unit: issue to register %0d with a write outstanding", issue_rd);

  // Results must target a register with an outstanding write
  a_alu_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (alu_fire && alu_rd != '0) |-> busy[alu_rd])
    else $error("writeback_unit: ALU result for idle register %0d", alu_rd);

  a_ld_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (ld_fire && ld_rd != '0) |-> busy[ld_rd])
    else $error("writeback_unit: load result for idle register %0d", ld_rd);

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: the model predicts readiness from its own queue occupancy.
module tb_writeback_unit;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int IW  = 5;
  localparam int LQD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic [IW-1:0] issue_rd;
  logic          alu_valid;
  logic          alu_ready;
  logic [IW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [IW-1:0] ld_rd;
  logic [2:0]    ld_funct3;
  logic [1:0]    ld_addr_lo;
  logic [31:0]   ld_word;
  logic          rf_wen;
  logic [IW-1:0] rf_rd;
  logic [DW-1:0] rf_rdv;
  logic [NR-1:0] busy;

  always #5 clk = ~clk;

  writeback_unit #(
    .DATA_WIDTH (DW),
    .NUM_REG    (NR),
    .IDX_WIDTH  (IW),
    .LQ_DEPTH   (LQD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_funct3   (ld_funct3),
    .ld_addr_lo  (ld_addr_lo),
    .ld_word     (ld_word),
    .rf_wen      (rf_wen),
    .rf_rd       (rf_rd),
    .rf_rdv      (rf_rdv),
    .busy        (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  typedef struct {
    logic [IW-1:0] rd;
    logic [DW-1:0] data;
  } mentry_t;

  mentry_t       m_q[$];
  logic [NR-1:0] m_busy;
  logic          m_wen;
  logic [IW-1:0] m_rd;
  logic [DW-1:0] m_rdv;
  bit            m_alu_acc;
  bit            m_ld_acc;

  logic [2:0]  ext_f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [1:0]  ext_off [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
  logic [31:0] ext_exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};

  // Load extension computed arithmetically from the selected byte/halfword value
  function automatic logic [31:0] ref_extend(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(off))) & 32'h0000_00FF;
    h = (w >> (16 * int'(off[1]))) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)    ? b - 32'd256     : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000)   ? h - 32'h1_0000  : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy = '0;
    m_wen  = 1'b0;
    m_rd   = '0;
    m_rdv  = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit            full;
    bit            sv;
    logic [IW-1:0] nrd;
    logic [DW-1:0] nd;
    mentry_t       e;
    full      = (m_q.size() >= LQD);
    m_alu_acc = alu_valid && !full;
    m_ld_acc  = ld_valid && !full;
    sv  = 1'b0;
    nrd = '0;
    nd  = '0;
    if (m_alu_acc) begin
      sv = 1'b1; nrd = alu_rd; nd = alu_data;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      sv = 1'b1; nrd = e.rd; nd = e.data;
    end
    if (m_ld_acc) begin
      e.rd   = ld_rd;
      e.data = ref_extend(ld_funct3, ld_addr_lo, ld_word);
      m_q.push_back(e);
    end
    if (m_wen) m_busy[m_rd] = 1'b0;
    if (issue_valid && issue_rd != '0) m_busy[issue_rd] = 1'b1;
    m_wen = sv && (nrd != '0);
    m_rd  = nrd;
    m_rdv = nd;
  endtask

  // One clock: model update, edge, settle, then drop the one-shot valids
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    ld_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0; ld_word = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({rf_wen, rf_rd, rf_rdv, busy, ld_ready, alu_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values: got wen=%b rd=%0d rdv=%h busy=%h ldr=%b alur=%b, want 0 0 0 0 1 1",
               rf_wen, rf_rd, rf_rdv, busy, ld_ready, alu_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_basic();
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    n_tests++;
    if (busy[5] !== 1'b1) begin
      n_fail++; $display("FAIL alu_busy_set: got %b want 1", busy[5]);
    end
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
    tick();
    n_tests++;
    if ({rf_wen, rf_rd, rf_rdv} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      n_fail++; $display("FAIL alu_write: got wen=%b rd=%0d rdv=%h want 1 5 12345678", rf_wen, rf_rd, rf_rdv);
    end
    n_tests++;
    if (busy[5] !== 1'b1) begin
      n_fail++; $display("FAIL alu_busy_hold: got %b want 1", busy[5]);
    end
    tick();
    n_tests++;
    if (rf_wen !== 1'b0 || busy[5] !== 1'b0) begin
      n_fail++; $display("FAIL alu_commit: got wen=%b busy5=%b want 0 0", rf_wen, busy[5]);
    end
  endtask

  task automatic test_load_extend();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_rd = IW'(10 + i);
      tick();
      ld_valid = 1'b1; ld_rd = IW'(10 + i); ld_funct3 = ext_f3[i];
      ld_addr_lo = ext_off[i]; ld_word = 32'h80FF_7F01;
      tick();
      n_tests++;
      if (rf_wen !== 1'b0) begin
        n_fail++; $display("FAIL load_early_%0d: got wen=%b want 0", i, rf_wen);
      end
      tick();
      n_tests++;
      if ({rf_wen, rf_rd, rf_rdv} !== {1'b1, IW'(10 + i), ext_exp[i]}) begin
        n_fail++; $display("FAIL load_extend_%0d: got wen=%b rd=%0d rdv=%h want 1 %0d %h",
                           i, rf_wen, rf_rd, rf_rdv, 10 + i, ext_exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] regs [5] = '{5'd7, 5'd8, 5'd16, 5'd17, 5'd18};
    foreach (regs[i]) begin
      issue_valid = 1'b1; issue_rd = regs[i];
      tick();
    end
    ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    alu_valid = 1'b1; alu_rd = 5'd16; alu_data = 32'hB000_0016;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_word = 32'hA000_0007;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd17; alu_data = 32'hB000_0017;
    ld_valid = 1'b1; ld_rd = 5'd8; ld_word = 32'hA000_0008;
    tick();
    n_tests++;
    if (ld_ready !== 1'b0 || alu_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall: got ldr=%b alur=%b want 0 0", ld_ready, alu_ready);
    end
    alu_valid = 1'b1; alu_rd = 5'd18; alu_data = 32'hB000_0018;
    tick();
    n_tests++;
    if ({rf_wen, rf_rd, rf_rdv} !== {1'b1, 5'd7, 32'hA000_0007}) begin
      n_fail++; $display("FAIL bp_head7: got wen=%b rd=%0d rdv=%h want 1 7 a0000007", rf_wen, rf_rd, rf_rdv);
    end
    n_tests++;
    if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_back: got alur=%b ldr=%b want 1 1", alu_ready, ld_ready);
    end
    alu_valid = 1'b1; alu_rd = 5'd18; alu_data = 32'hB000_0018;
    tick();
    n_tests++;
    if ({rf_wen, rf_rd, rf_rdv} !== {1'b1, 5'd18, 32'hB000_0018}) begin
      n_fail++; $display("FAIL bp_alu18: got wen=%b rd=%0d rdv=%h want 1 18 b0000018", rf_wen, rf_rd, rf_rdv);
    end
    tick();
    n_tests++;
    if ({rf_wen, rf_rd, rf_rdv} !== {1'b1, 5'd8, 32'hA000_0008}) begin
      n_fail++; $display("FAIL bp_head8: got wen=%b rd=%0d rdv=%h want 1 8 a0000008", rf_wen, rf_rd, rf_rdv);
    end
    tick();
    n_tests++;
    if (busy !== '0) begin
      n_fail++; $display("FAIL bp_drained: got busy=%h want 0", busy);
    end
  endtask

  task automatic test_issue_collision();
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0001;
    tick();
    n_tests++;
    if (rf_wen !== 1'b1 || rf_rd !== 5'd3) begin
      n_fail++; $display("FAIL coll_commit: got wen=%b rd=%0d want 1 3", rf_wen, rf_rd);
    end
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    n_tests++;
    if (busy[3] !== 1'b1) begin
      n_fail++; $display("FAIL coll_set_wins: got busy3=%b want 1", busy[3]);
    end
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0002;
    tick();
    tick();
    n_tests++;
    if (busy[3] !== 1'b0) begin
      n_fail++; $display("FAIL coll_clear: got busy3=%b want 0", busy[3]);
    end
  endtask

  task automatic test_rd_zero();
    issue_valid = 1'b1; issue_rd = 5'd20;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (alu_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd0_ready: got %b want 1", alu_ready);
    end
    tick();
    n_tests++;
    if (rf_wen !== 1'b0 || busy !== 32'h0010_0000) begin
      n_fail++; $display("FAIL rd0_nowrite: got wen=%b busy=%h want 0 00100000", rf_wen, busy);
    end
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h0000_0020;
    tick();
    tick();
    n_tests++;
    if (busy !== '0) begin
      n_fail++; $display("FAIL rd0_cleanup: got busy=%h want 0", busy);
    end
  endtask

  task automatic test_reset_midop();
    logic [IW-1:0] regs [3] = '{5'd9, 5'd11, 5'd12};
    foreach (regs[i]) begin
      issue_valid = 1'b1; issue_rd = regs[i];
      tick();
    end
    ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_word = 32'h0000_0009;
    tick();
    ld_valid = 1'b1; ld_rd = 5'd11; ld_word = 32'h0000_0011;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h0000_0012;
    tick();
    n_tests++;
    if (ld_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_full: got ldr=%b want 0", ld_ready);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({rf_wen, rf_rd, rf_rdv, busy, ld_ready, alu_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_values: got wen=%b rd=%0d rdv=%h busy=%h ldr=%b alur=%b, want 0 0 0 0 1 1",
               rf_wen, rf_rd, rf_rdv, busy, ld_ready, alu_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (rf_wen !== 1'b0) begin
        n_fail++; $display("FAIL midrst_nowen_%0d: got %b want 0", i, rf_wen);
      end
    end
    rst_n = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    n_tests++;
    if (busy !== 32'h0000_1000 || ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_reissue: got busy=%h ldr=%b want 00001000 1", busy, ld_ready);
    end
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hCAFE_0001;
    tick();
    n_tests++;
    if ({rf_wen, rf_rd, rf_rdv} !== {1'b1, 5'd12, 32'hCAFE_0001}) begin
      n_fail++; $display("FAIL midrst_write: got wen=%b rd=%0d rdv=%h want 1 12 cafe0001", rf_wen, rf_rd, rf_rdv);
    end
    tick();
  endtask

  task automatic test_random();
    logic [NR-1:0] pend;
    int            cands[$];
    int            idx;
    int            r;
    bit            did_issue;
    pend = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      did_issue = 1'b0;
      if (cyc < 580) begin
        if ($urandom_range(0, 2) == 0) begin
          r = $urandom_range(1, NR - 1);
          if (!m_busy[r]) begin
            issue_valid = 1'b1; issue_rd = IW'(r); did_issue = 1'b1;
          end
        end
        cands.delete();
        for (int i = 1; i < NR; i++) if (pend[i]) cands.push_back(i);
        if ($urandom_range(0, 3) != 0) begin
          alu_valid = 1'b1; alu_data = $urandom;
          alu_rd = '0;
          if (cands.size() > 0 && $urandom_range(0, 7) != 0) begin
            idx = $urandom_range(0, cands.size() - 1);
            alu_rd = IW'(cands[idx]);
            cands.delete(idx);
          end
        end
        if ($urandom_range(0, 1) != 0) begin
          ld_valid = 1'b1; ld_word = $urandom;
          ld_funct3 = 3'($urandom_range(0, 7)); ld_addr_lo = 2'($urandom_range(0, 3));
          ld_rd = '0;
          if (cands.size() > 0 && $urandom_range(0, 7) != 0) begin
            idx = $urandom_range(0, cands.size() - 1);
            ld_rd = IW'(cands[idx]);
          end
        end
      end
      tick();
      if (m_alu_acc && alu_rd != '0) pend[alu_rd] = 1'b0;
      if (m_ld_acc && ld_rd != '0) pend[ld_rd] = 1'b0;
      if (did_issue) pend[issue_rd] = 1'b1;
      n_tests++;
      if (rf_wen !== m_wen || (m_wen && {rf_rd, rf_rdv} !== {m_rd, m_rdv}) || busy !== m_busy ||
          ld_ready !== (m_q.size() < LQD) || alu_ready !== (m_q.size() < LQD)) begin
        n_fail++;
        $display("FAIL random_c%0d: got wen=%b rd=%0d rdv=%h busy=%h ldr=%b alur=%b want wen=%b rd=%0d rdv=%h busy=%h rdy=%b",
                 cyc, rf_wen, rf_rd, rf_rdv, busy, ld_ready, alu_ready,
                 m_wen, m_rd, m_rdv, m_busy, (m_q.size() < LQD));
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_load_extend();
    test_backpressure();
    test_issue_collision();
    test_rd_zero();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
